// File: rtl/reg_array_stream_reader_pkg.sv
// ----------------------------------------------------------------------------
// reg_array_stream_reader_pkg
//   Definitions shared by the register-array read sequencer and the array
//   it reads from:
//     - state encoding of the read sequencer (IDLE / READ / DRAIN)
//     - clogb2(): address width needed for a given number of entries
//   No ports (package).
// ----------------------------------------------------------------------------
package reg_array_stream_reader_pkg;

  // State encoding. Kept as localparams so that other blocks, such as status
  // registers or debug taps, can decode a raw state value without the enum type.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_DRAIN = S_DRAIN
  } rd_state_t;

  // Number of bits needed to address 'depth' entries (ceil(log2(depth))).
  // Never returns less than 1, so a one-entry array still gets a real
  // address bus.
  function automatic int clogb2(input int depth);
    int bits;
    bits = 0;
    for (int v = depth - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage : reg_array_stream_reader_pkg

// File: rtl/reg_array_stream_reader_stream_out_reg.sv
// ----------------------------------------------------------------------------
// stream_out_reg
//   One-entry output register slot for a valid/ready stream. The owner decides
//   when the slot may be written: it asserts i_load only when the slot is empty
//   or is being emptied in this cycle. A load with i_in_valid=0 empties the slot.
//   The data field is written only by a valid load. An emptying load or a
//   flush leaves it unchanged.
//
// Ports
//   i_clk       clock
//   i_reset     asynchronous active-high reset (all outputs to 0)
//   i_flush     synchronous cancel: drops valid/last, priority over i_load
//   i_load      write the slot this cycle
//   i_in_valid  valid bit to store on load
//   i_in_data   data word to store on a valid load
//   i_in_last   last flag to store on load
//   o_data      registered stream data
//   o_valid     registered stream valid
//   o_last      registered stream last flag
// ----------------------------------------------------------------------------
module stream_out_reg #(
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_last
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_in_valid;
      r_last  <= i_in_valid & i_in_last;
      if (i_in_valid) begin
        r_data <= i_in_data;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule : stream_out_reg

// File: rtl/reg_array_stream_reader.sv
// ----------------------------------------------------------------------------
// reg_array_stream_reader
//   Read-side sequencer for a distributed-RAM register array that has a
//   combinational read port. A start pulse begins a pass. The pass walks
//   addresses 0..n-1 on o_addrb and captures i_doutb into a one-entry output
//   register. Each entry leaves on a valid/ready stream with a last flag and
//   full backpressure.
//
// Ports
//   i_clk         clock
//   i_reset       asynchronous active-high reset
//   i_start       begin a pass (sampled only in IDLE)
//   i_nentries    entries in this pass, sampled with i_start (saturates at RAM_DEPTH)
//   i_abort       synchronous cancel of the current pass (priority over start)
//   o_addrb       registered read address to the array
//   i_doutb       combinational read data from the array
//   o_dout_data   stream data (registered)
//   o_dout_valid  stream valid
//   i_dout_ready  stream ready from consumer
//   o_dout_last   high with the final entry of the pass
//   o_busy        high in READ or DRAIN
//   o_done        one-cycle pulse when a pass completes (or when a zero-length
//                 pass is requested)
// ----------------------------------------------------------------------------
module reg_array_stream_reader
  import reg_array_stream_reader_pkg::*;
#(
  parameter  int RAM_WIDTH = 12,
  parameter  int RAM_DEPTH = 128,
  localparam int ADDR_W    = clogb2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ADDR_W:0]      i_nentries,
  input  logic                 i_abort,
  output logic [ADDR_W-1:0]    o_addrb,
  input  logic [RAM_WIDTH-1:0] i_doutb,
  output logic [RAM_WIDTH-1:0] o_dout_data,
  output logic                 o_dout_valid,
  input  logic                 i_dout_ready,
  output logic                 o_dout_last,
  output logic                 o_busy,
  output logic                 o_done
);

  // The remaining-entries counter is one bit wider than the address, so it
  // can hold RAM_DEPTH itself.
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_addrb;
  logic [ADDR_W:0]   r_remaining;
  logic              r_busy;
  logic              r_done;

  logic              w_load;        // output slot free or being emptied now
  logic              w_xfer;        // handshake completes at this edge
  logic              w_last_entry;  // the entry being read is the final one
  logic [ADDR_W:0]   w_start_count; // saturated entry count for a new pass
  logic              w_so_load;
  logic              w_so_valid;
  logic              w_so_last;

  assign w_xfer       = o_dout_valid & i_dout_ready;
  assign w_load       = ~o_dout_valid | i_dout_ready;
  assign w_last_entry = (r_remaining == CNT_ONE);

  always_comb begin
    w_start_count = i_nentries;
    if (i_nentries > DEPTH_CNT) begin
      w_start_count = DEPTH_CNT;
    end
  end

  // Controls for the output slot. In READ, each free slot takes the word
  // currently addressed. In DRAIN, the slot is emptied only when the final
  // word is accepted, so valid never drops without a transfer.
  always_comb begin
    w_so_load  = 1'b0;
    w_so_valid = 1'b0;
    w_so_last  = 1'b0;
    case (r_state)
      ST_READ: begin
        if (w_load) begin
          w_so_load  = 1'b1;
          w_so_valid = 1'b1;
          w_so_last  = w_last_entry;
        end
      end
      ST_DRAIN: begin
        if (w_xfer) begin
          w_so_load = 1'b1;
        end
      end
      default: begin
        w_so_load = 1'b0;
      end
    endcase
  end

  // Sequencer: state, address counter, remaining counter, busy and done.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_addrb     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        // A cancelled pass does not complete, so there is no done pulse.
        r_state     <= ST_IDLE;
        r_addrb     <= '0;
        r_remaining <= '0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (i_nentries == '0) begin
                // Empty pass: report completion without reading anything.
                r_done <= 1'b1;
              end else begin
                r_addrb     <= '0;
                r_remaining <= w_start_count;
                r_busy      <= 1'b1;
                r_state     <= ST_READ;
              end
            end
          end
          ST_READ: begin
            if (w_load) begin
              r_remaining <= r_remaining - CNT_ONE;
              if (w_last_entry) begin
                // Keep the address on the final entry so that it never
                // wraps past the end of the pass.
                r_state <= ST_DRAIN;
              end else begin
                r_addrb <= r_addrb + ADDR_ONE;
              end
            end
          end
          ST_DRAIN: begin
            if (w_xfer) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_addrb     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  stream_out_reg #(
    .WIDTH (RAM_WIDTH)
  ) u_stream_out_reg (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (i_abort),
    .i_load     (w_so_load),
    .i_in_valid (w_so_valid),
    .i_in_data  (i_doutb),
    .i_in_last  (w_so_last),
    .o_data     (o_dout_data),
    .o_valid    (o_dout_valid),
    .o_last     (o_dout_last)
  );

  assign o_addrb = r_addrb;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule : reg_array_stream_reader

// File: tb/tb_reg_array_stream_reader.sv
module tb_reg_array_stream_reader;

  localparam int W      = 12;
  localparam int DEPTH  = 128;
  localparam int AW     = 7;
  localparam int M_HIGH = 0;   // ready held high
  localparam int M_TOG  = 1;   // ready pattern 1,0,0,1,0,0,...
  localparam int M_RND  = 2;   // ready random, mostly high

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   nentries;
  logic          abort;
  logic [AW-1:0] addrb;
  logic [W-1:0]  doutb;
  logic [W-1:0]  dout_data;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          done;

  logic [W-1:0]  mem [0:DEPTH-1];

  int checks;
  int failures;

  typedef struct {
    int n;
    int mode;
    int exp_beats;
  } vec_t;

  vec_t vecs [8];

  reg_array_stream_reader #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_nentries   (nentries),
    .i_abort      (abort),
    .o_addrb      (addrb),
    .i_doutb      (doutb),
    .o_dout_data  (dout_data),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_dout_last  (dout_last),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Array with a combinational read port.
  assign doutb = mem[addrb];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == M_TOG) return ((cyc % 3) == 0);
    if (mode == M_RND) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Expects to be called at the negedge right after the edge that sampled
  // start. It returns at the negedge where the done pulse must be visible.
  task automatic collect(input int exp_beats, input int mode, input string name);
    logic [W-1:0] q [$];
    logic [W-1:0] exp_word;
    logic [W-1:0] prev_data;
    logic         prev_last;
    logic         prev_stall;
    int           got, cyc, max_addr;
    bit           fin, early_done, busy_bad, stable_bad, extra;
    for (int i = 0; i < exp_beats; i++) q.push_back(mem[i]);
    chk({name, "_busy_after_start"}, int'(busy), 1);
    chk({name, "_valid_after_start"}, int'(dout_valid), 0);
    got = 0; cyc = 0; max_addr = 0; fin = 0;
    early_done = 0; busy_bad = 0; stable_bad = 0; extra = 0;
    prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    while (!fin && cyc < 2000) begin
      if (cyc == 1) chk({name, "_first_valid_latency"}, int'(dout_valid), 1);
      if (done) early_done = 1;
      if (!busy) busy_bad = 1;
      if (int'(addrb) > max_addr) max_addr = int'(addrb);
      if (prev_stall && (!dout_valid || dout_data != prev_data || dout_last != prev_last))
        stable_bad = 1;
      dout_ready = pick_ready(mode, cyc);
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          extra = 1;
        end else begin
          exp_word = q.pop_front();
          chk({name, "_data"}, int'(dout_data), int'(exp_word));
          chk({name, "_last"}, int'(dout_last), (q.size() == 0) ? 1 : 0);
          got++;
          if (q.size() == 0) fin = 1;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
      prev_last  = dout_last;
      @(negedge clk);
      cyc++;
    end
    chk({name, "_beats"}, got, exp_beats);
    chk({name, "_extra_beat"}, int'(extra), 0);
    chk({name, "_early_done"}, int'(early_done), 0);
    chk({name, "_busy_during_pass"}, int'(busy_bad), 0);
    chk({name, "_stable_in_stall"}, int'(stable_bad), 0);
    chk({name, "_addrb_max"}, max_addr, exp_beats - 1);
    chk({name, "_done_pulse"}, int'(done), 1);
    chk({name, "_busy_end"}, int'(busy), 0);
    chk({name, "_valid_end"}, int'(dout_valid), 0);
    chk({name, "_last_end"}, int'(dout_last), 0);
    if (!fin) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    $display("pass %s: beats=%0d expected=%0d cycles=%0d", name, got, exp_beats, cyc);
  endtask

  task automatic run_pass(input int n, input int mode, input int exp_beats, input string name);
    @(negedge clk);
    start = 1'b1;
    nentries = (AW+1)'(n);
    dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (exp_beats == 0) begin
      chk({name, "_zero_done"}, int'(done), 1);
      chk({name, "_zero_busy"}, int'(busy), 0);
      chk({name, "_zero_valid"}, int'(dout_valid), 0);
      $display("pass %s: n=0 done=%0d busy=%0d", name, done, busy);
    end else begin
      collect(exp_beats, mode, name);
    end
    @(negedge clk);
    chk({name, "_done_cleared"}, int'(done), 0);
    chk({name, "_idle_valid"}, int'(dout_valid), 0);
  endtask

  initial begin
    int cnt, dones, guard, n;
    checks = 0;
    failures = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i + 'h100);
    reset = 1'b1; start = 1'b0; nentries = '0; abort = 1'b0; dout_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_data", int'(dout_data), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_last", int'(dout_last), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_addrb", int'(addrb), 0);
    reset = 1'b0;

    // Table of passes: entry count, ready pattern, expected beat count
    vecs[0] = '{n: 5,   mode: M_HIGH, exp_beats: 5};
    vecs[1] = '{n: 4,   mode: M_TOG,  exp_beats: 4};
    vecs[2] = '{n: 0,   mode: M_HIGH, exp_beats: 0};
    vecs[3] = '{n: 200, mode: M_HIGH, exp_beats: 128};
    vecs[4] = '{n: 1,   mode: M_HIGH, exp_beats: 1};
    vecs[5] = '{n: 128, mode: M_RND,  exp_beats: 128};
    vecs[6] = '{n: 129, mode: M_TOG,  exp_beats: 128};
    vecs[7] = '{n: 7,   mode: M_RND,  exp_beats: 7};
    for (int i = 0; i < 8; i++) begin
      run_pass(vecs[i].n, vecs[i].mode, vecs[i].exp_beats, $sformatf("vec%0d", i));
    end

    // Random passes against the model: beat count is min(n, depth)
    for (int r = 0; r < 6; r++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      run_pass(n, M_RND, (n > DEPTH) ? DEPTH : n, $sformatf("rnd%0d", r));
    end

    // Abort on the third beat while stalled
    @(negedge clk);
    start = 1'b1; nentries = 8'd10; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; guard = 0;
    while (cnt < 2 && guard < 50) begin
      @(negedge clk);
      if (dout_valid) cnt++;
      guard++;
    end
    @(negedge clk);
    dout_ready = 1'b0;
    chk("abort_third_valid", int'(dout_valid), 1);
    chk("abort_third_data", int'(dout_data), 'h102);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", int'(dout_valid), 0);
    chk("abort_last", int'(dout_last), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addrb", int'(addrb), 0);
    chk("abort_no_done", int'(done), 0);
    @(negedge clk);
    chk("abort_no_done_later", int'(done), 0);
    $display("abort sequence: valid=%0d busy=%0d done=%0d", dout_valid, busy, done);
    run_pass(2, M_HIGH, 2, "after_abort");

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; nentries = 8'd3; dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; nentries = 8'd100;
    @(negedge clk);
    start = 1'b0;
    dout_ready = 1'b1;
    cnt = 0; dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (dout_valid) cnt++;
      if (done) dones++;
      @(negedge clk);
    end
    chk("busy_start_beats", cnt, 3);
    chk("busy_start_dones", dones, 1);
    $display("start-while-busy: beats=%0d dones=%0d", cnt, dones);

    // Back-to-back: start raised in the done cycle
    @(negedge clk);
    start = 1'b1; nentries = 8'd2; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(2, M_HIGH, "b2b_first");
    start = 1'b1; nentries = 8'd3;
    @(negedge clk);
    start = 1'b0;
    collect(3, M_HIGH, "b2b_second");
    @(negedge clk);
    chk("b2b_done_cleared", int'(done), 0);

    // Asynchronous reset in the middle of a pass, off the clock edge
    @(negedge clk);
    start = 1'b1; nentries = 8'd50; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_data", int'(dout_data), 0);
    chk("midreset_valid", int'(dout_valid), 0);
    chk("midreset_last", int'(dout_last), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_addrb", int'(addrb), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_no_done", int'(done), 0);
    chk("midreset_idle_busy", int'(busy), 0);
    $display("mid-pass reset: valid=%0d busy=%0d done=%0d", dout_valid, busy, done);
    run_pass(3, M_TOG, 3, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_array_stream_reader
